period_counter: RTL
===================

Name: period_counter

Overview:
Measures the period of an external square wave and supplies it as the divisor to the downstream divider stage. That stage converts the period into a frequency. It counts clock ticks between two consecutive rising edges of a synchronized input. It uses the same start/ready/done handshake as the divider. o_period feeds the divider's i_divisor, and o_done can drive the divider's i_start.

Parameters:
WIDTH, 32, width of o_period; must match the divider WIDTH.
TICK_DIV, 1, clock cycles per period unit (prescaler); must be at least 1.

Ports:
i_clk  in  1  system clock, 100 MHz
i_rst  in  1  asynchronous, active-high reset
i_start  in  1  one-cycle request to begin a measurement; sampled only in IDLE
i_sig  in  1  asynchronous input signal to be measured
o_ready  out  1  high while in IDLE; new start accepted
o_done  out  1  one-cycle pulse when o_period/o_ovf become valid
o_period  out  WIDTH  measured period in ticks; held until next completion
o_ovf  out  1  measurement saturated (no edge within range); held with o_period

Behaviour:
- Reset (async, any state): state=IDLE, o_ready=1, o_done=0, o_period=0, o_ovf=0. Synchronizer flops, prescaler and counter are cleared.
- Input path: i_sig passes through a 2-FF synchronizer plus one edge register.
- A rising edge (edge = sync & ~prev) is detected 3 cycles after i_sig rises.
- Edges are detected on transitions only; i_sig already high at start does not count as an edge.
- States are IDLE, WAIT_FIRST, COUNT and DONE.
- IDLE:
  - o_ready=1.
  - On i_start=1, go to WAIT_FIRST, clear o_ovf, and clear the counter and prescaler. o_period keeps its old value.
- WAIT_FIRST:
  - o_ready=0.
  - On a detected edge, go to COUNT and clear the counter and prescaler.
  - If (2^WIDTH)*TICK_DIV cycles elapse without an edge, go to DONE with o_period={WIDTH{1}} and o_ovf=1.
- COUNT:
  - Let N be the number of clock cycles between the first and second detected edges.
  - On the second detected edge, o_period=floor(N/TICK_DIV) and o_ovf=0; go to DONE.
  - Example: with TICK_DIV=1 and i_sig period 100 cycles, o_period=100.
  - If floor(N/TICK_DIV) would exceed 2^WIDTH-1, saturate immediately: o_period=all ones, o_ovf=1, go to DONE. Do not wait for the edge.
  - An edge arriving in the same cycle as the overflow threshold counts as the edge. If the value equals exactly 2^WIDTH-1, there is no ovf.
- DONE:
  - o_done=1 for exactly one cycle, then go to IDLE (o_ready=1 on the next cycle).
  - o_period and o_ovf are stable from the o_done cycle until the next DONE or reset.
- i_start outside IDLE is ignored, with no effect on the measurement in progress.
- i_start held high continuously in IDLE causes back-to-back measurements. Each one still needs its own two edges.
- Edges seen in IDLE or DONE are ignored.
- Counter arithmetic is unsigned. The prescaler runs 0..TICK_DIV-1 and increments the counter on wrap. There is no wrap-around of the counter; it saturates only.
- Reset asserted mid-measurement aborts the measurement with no o_done pulse. Outputs return to their reset values.

Test Plan:
- Reset, i_sig period 100 cycles (50/50), start -> o_done once, o_period=100, o_ovf=0, o_ready returns high 1 cycle later.
- TICK_DIV=10, i_sig period 1234 cycles -> o_period=123, o_ovf=0.
- WIDTH=8, TICK_DIV=1:
  - period 255 cycles -> o_period=255, o_ovf=0.
  - period 300 cycles -> o_period=255, o_ovf=1, o_done 256 cycles after the first detected edge.
- i_sig held constant after start (WIDTH=8) -> o_ovf=1, o_period=255 after 256 cycles in WAIT_FIRST.
- Pulse i_start during COUNT, and start a measurement while i_sig is already high -> extra starts ignored. The measurement begins on the next true rising edge; o_period is still correct.
- Assert i_rst mid-COUNT -> no o_done, outputs at reset values, o_ready=1. A following measurement of 100 cycles -> 100.

Source files
------------

// File: rtl/period_counter.sv
// Period counter: measures clock ticks between two consecutive rising edges of an
// asynchronous input and hands the result to a divider via a start/ready/done handshake.
module period_counter #(
    parameter int WIDTH    = 32,
    parameter int TICK_DIV = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_sig,
    output logic             o_ready,
    output logic             o_done,
    output logic [WIDTH-1:0] o_period,
    output logic             o_ovf
);

    localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FIRST,
        COUNT,
        DONE
    } state_t;

    state_t           r_state;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic [PW-1:0]    r_presc;
    logic [WIDTH-1:0] r_count;
    logic             r_ready;
    logic             r_done;
    logic             r_ovf;
    logic [WIDTH-1:0] r_period;

    logic             w_edge;
    logic             w_wrap;
    logic [PW-1:0]    w_presc_next;
    logic [WIDTH:0]   w_count_next;
    logic             w_sat;

    assign w_edge       = r_sync2 & ~r_prev;
    assign w_wrap       = (r_presc == PRESC_LAST);
    assign w_presc_next = w_wrap ? '0 : r_presc + 1'b1;
    // One extra bit so the tick that would exceed the output range is visible.
    assign w_count_next = {1'b0, r_count} + (WIDTH+1)'(w_wrap);
    assign w_sat        = w_count_next[WIDTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_sig;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_presc  <= '0;
            r_count  <= '0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
            r_period <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state <= WAIT_FIRST;
                        r_ready <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_presc <= '0;
                        r_count <= '0;
                    end
                end
                WAIT_FIRST: begin
                    if (w_edge) begin
                        r_state <= COUNT;
                        r_presc <= '0;
                        r_count <= '0;
                    end else if (w_sat) begin
                        r_state  <= DONE;
                        r_done   <= 1'b1;
                        r_period <= '1;
                        r_ovf    <= 1'b1;
                    end else begin
                        r_presc <= w_presc_next;
                        r_count <= w_count_next[WIDTH-1:0];
                    end
                end
                COUNT: begin
                    // The closing edge reports this cycle's tick too, hence w_count_next.
                    if (w_edge || w_sat) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        if (w_sat) begin
                            r_period <= '1;
                            r_ovf    <= 1'b1;
                        end else begin
                            r_period <= w_count_next[WIDTH-1:0];
                            r_ovf    <= 1'b0;
                        end
                    end else begin
                        r_presc <= w_presc_next;
                        r_count <= w_count_next[WIDTH-1:0];
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_ready  = r_ready;
    assign o_done   = r_done;
    assign o_period = r_period;
    assign o_ovf    = r_ovf;

endmodule
